serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Bit-serial counterpart of the 4-bit ripple adder/subtractor: same operands, mode and result
//  semantics, but one full-adder slice processes operands LSB-first, one bit per clock.
//  Sits where area beats latency; a start/done handshake frames each operation.
//  Result (s, cout) is bit-identical to the parallel unit for all inputs; also reports ovf.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>= 2)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  a      in   WIDTH  minuend / augend, captured on accepted start
//  b      in   WIDTH  subtrahend / addend, captured on accepted start
//  m      in   1      mode: 0 = add (a+b), 1 = subtract (a + ~b + 1); captured on accepted start
//  busy   out  1      high while an operation is in flight
//  done   out  1      one-cycle pulse; s/cout/ovf valid from this cycle
//  s      out  WIDTH  result, held until the next done
//  cout   out  1      carry out of MSB (subtract: 1 = no borrow, a >= b unsigned)
//  ovf    out  1      two's-complement overflow = carry-into-MSB XOR cout
// BEHAVIOUR
//  - Reset (async assert): state IDLE; busy=0, done=0, s=0, cout=0, ovf=0; shift regs, count cleared.
//  - States: IDLE, RUN. Result outputs are registered; done is registered.
//  - IDLE: start=1 at edge k -> load A<=a, B<=b ^ {WIDTH{m}}, c<=m, cnt<=0; go RUN; busy=1 after k.
//  - RUN, each edge: bit = A[0]^B[0]^c; c <= carry(A[0],B[0],c); A,B shift right;
//    sum shift reg shifts right with bit entering at MSB; cnt++.
//    Bits processed at edges k+1..k+WIDTH. At edge k+WIDTH (cnt==WIDTH-1):
//    s <= completed sum, cout <= final carry, ovf <= carry-into-MSB ^ final carry,
//    done <= 1, busy <= 0, state <= IDLE.
//  - Latency: done high in the cycle after edge k+WIDTH; single-op period = WIDTH+1 cycles.
//  - done is high for exactly one cycle; s/cout/ovf change only on that edge.
//  - start while busy=1: ignored, no queueing; captured operands unaffected by later a/b/m changes.
//  - start high in the done cycle: accepted (busy=0); continuous start -> done every WIDTH+1 cycles.
//  - Carry-into-MSB is the carry register value before the last bit; keep it in a flop.
//  - rst mid-RUN: abort immediately, no done pulse, outputs return to reset values.
//  - Arithmetic is modulo 2^WIDTH; no saturation. cnt width = $clog2(WIDTH).
// STRUCTURE
//  - Package serial_addsub_pkg: state enum {IDLE, RUN}; MODE_ADD=1'b0, MODE_SUB=1'b1.
//  - One sub-module serial_fa_bit: combinational sum/carry of (x, y, cin); parent owns carry flop.
//  - Top holds FSM, counter, operand shift regs, sum shift reg, result regs.
// TESTING (WIDTH=4)
//  - m=1, a=4'b1000, b=4'b1010, start 1 cycle -> done after 5 cycles; s=4'b1110, cout=0, ovf=0.
//  - m=0, a=4'b0111, b=4'b0001 -> s=4'b1000, cout=0, ovf=1; m=0, a=4'hF, b=4'h1 -> s=0, cout=1, ovf=0.
//  - m=1, a=4'b0101, b=4'b0101 -> s=4'b0000, cout=1, ovf=0; busy high exactly 4 cycles.
//  - start pulsed again at cycle 2 of RUN with a=0,b=0,m=0 -> ignored; first result delivered.
//  - start held high 3 ops -> done pulses at period 5, each s matches operands captured at accept.
//  - rst asserted during 2nd RUN cycle -> busy=0, s=0, no done; next start completes normally.
//  - Random 1000 ops vs reference model {cout,s}=a+(b^{4{m}})+m, ovf per sign rule; all match.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_pkg
//  Description : Shared types, mode encodings and the full-adder carry helper
//                for the bit-serial adder/subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_addsub_pkg;

    // Two-state controller: waiting for a request, or shifting bits through.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Operation select on the m input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Majority of three: the carry out of a full-adder slice.
    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Subtract is a + ~b + 1: invert the addend and inject a carry of one.
    function automatic logic mode_invert(input logic mode);
        return (mode == MODE_SUB);
    endfunction

    function automatic logic mode_carry_in(input logic mode);
        return (mode == MODE_ADD) ? 1'b0 : 1'b1;
    endfunction

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fa_bit
//  Description : Single combinational full-adder slice. The carry flop lives
//                in the parent so this slice can be reused every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_fa_bit
    import serial_addsub_pkg::*;
(
    input  logic i_x,
    input  logic i_y,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    // Sum and carry of one bit position.
    always_comb begin
        o_sum  = i_x ^ i_y ^ i_cin;
        o_cout = fa_carry(i_x, i_y, i_cin);
    end

endmodule : serial_fa_bit
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial adder/subtractor. Operands are captured on an
//                accepted start, processed LSB-first one bit per clock through
//                a single full-adder slice, and the result (s, cout, ovf) is
//                registered together with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    // Bit counter is just wide enough to index WIDTH positions.
    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // augend/minuend, shifted right each bit
    logic [WIDTH-1:0] r_b;      // addend, already inverted for subtract
    logic [WIDTH-1:0] r_sum;    // partial sum, bits enter at the MSB
    logic             r_c;      // running carry; before the last bit it is the carry into the MSB
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_bit;
    logic             w_carry;
    logic             w_inv;

    assign w_inv = mode_invert(m);

    serial_fa_bit u_fa (
        .i_x    (r_a[0]),
        .i_y    (r_b[0]),
        .i_cin  (r_c),
        .o_sum  (w_bit),
        .o_cout (w_carry)
    );

    // Controller and datapath: accept in IDLE, shift one bit per cycle in RUN,
    // publish the result and pulse done on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{w_inv}};
                        r_c     <= mode_carry_in(m);
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum <= {w_bit, r_sum[WIDTH-1:1]};
                    r_c   <= w_carry;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_last) begin
                        // r_c still holds the carry into the MSB at this edge.
                        r_s     <= {w_bit, r_sum[WIDTH-1:1]};
                        r_cout  <= w_carry;
                        r_ovf   <= r_c ^ w_carry;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Self-checking bench for serial_addsub (WIDTH=4). Expected
//                results are queued when an operation is launched and popped
//                by a monitor on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_addsub;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } res_t;

    res_t sb_q[$];
    int   done_cyc[$];
    res_t exp_r;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   cyc    = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: {cout,s} = a + (b ^ {m}) + m; overflow by the sign rule.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic md);
        logic [WIDTH-1:0] yx;
        logic [WIDTH:0]   t;
        res_t             r;
        yx     = y ^ {WIDTH{md}};
        t      = {1'b0, x} + {1'b0, yx} + {{WIDTH{1'b0}}, md};
        r.s    = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (x[WIDTH-1] == yx[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest launched op.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            done_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_r = sb_q.pop_front();
                check_val("s",    32'(s),    32'(exp_r.s));
                check_val("cout", 32'(cout), 32'(exp_r.cout));
                check_val("ovf",  32'(ovf),  32'(exp_r.ovf));
            end
        end
    end

    // Launch one op from idle, then wait for its done; reports latency and busy cycles.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic md,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; m = md; start = 1'b1;
        sb_q.push_back(model(x, y, md));
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        if (!done) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 20);
        if (!done) check_val("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        int d0;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; m = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_s",    32'(s),    32'd0);
        check_val("rst_cout", 32'(cout), 32'd0);
        check_val("rst_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        // Directed cases.
        run_op(4'b1000, 4'b1010, 1'b1, lat, bc);
        check_val("latency", 32'(lat), 32'(WIDTH + 1));
        check_val("busy_cycles_a", 32'(bc), 32'(WIDTH));
        run_op(4'b0111, 4'b0001, 1'b0, lat, bc);
        run_op(4'hF, 4'h1, 1'b0, lat, bc);
        run_op(4'b0101, 4'b0101, 1'b1, lat, bc);
        check_val("busy_cycles_b", 32'(bc), 32'(WIDTH));

        // Start while busy is ignored; operand changes after accept do not matter.
        @(negedge clk);
        a = 4'd3; b = 4'd4; m = 1'b0; start = 1'b1;
        sb_q.push_back(model(4'd3, 4'd4, 1'b0));
        @(posedge clk);
        #1 start = 1'b0; a = 4'hF; b = 4'hF; m = 1'b1;
        d0 = n_done;
        @(negedge clk);
        @(negedge clk);
        a = '0; b = '0; m = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_during_run", 32'(busy), 32'd1);
        repeat (8) @(negedge clk);
        check_val("ignored_start_dones", 32'(n_done - d0), 32'd1);

        // Continuous start: back-to-back ops, done every WIDTH+1 cycles.
        done_cyc.delete();
        @(negedge clk);
        a = 4'd2; b = 4'd3; m = 1'b0; start = 1'b1;
        sb_q.push_back(model(4'd2, 4'd3, 1'b0));
        @(posedge clk);
        #1 a = 4'd9; b = 4'd4; m = 1'b1;
        sb_q.push_back(model(4'd9, 4'd4, 1'b1));
        wait_done();
        @(posedge clk);
        #1 a = 4'd6; b = 4'd7; m = 1'b0;
        sb_q.push_back(model(4'd6, 4'd7, 1'b0));
        wait_done();
        @(posedge clk);
        #1 start = 1'b0; a = 4'hC; b = 4'h3; m = 1'b1;
        wait_done();
        #1;
        check_val("cont_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            check_val("cont_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'(WIDTH + 1));
            check_val("cont_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'(WIDTH + 1));
        end

        // Reset during the second RUN cycle aborts without a done pulse.
        @(negedge clk);
        a = 4'd1; b = 4'd2; m = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_s",    32'(s),    32'd0);
        check_val("abort_cout", 32'(cout), 32'd0);
        d0 = n_done;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_val("abort_no_done", 32'(n_done - d0), 32'd0);
        run_op(4'hA, 4'h3, 1'b0, lat, bc);
        check_val("post_abort_latency", 32'(lat), 32'(WIDTH + 1));

        // Random operations against the reference.
        for (int i = 0; i < 1000; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), lat, bc);
        end

        @(negedge clk);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_addsub
`default_nettype wire
